alu_result_display: RTL and testbench

Downstream consumer of the 4-bit `alu` (A, B, 2-bit `ctrl`, 8-bit `result`). On a load strobe it captures the ALU result and converts it to three BCD digits with a sequential double-dabble engine, one shift per cycle. When `ctrl` selects subtraction it also extracts the sign. It then time-multiplexes the value onto a 4-digit active-low seven-segment display, with leading-zero blanking and a minus-sign digit.

---
 rtl/alu_disp_pkg.sv | 41 ++++
 rtl/alu_result_display_bcd_to_seg7.sv | 27 ++
 rtl/alu_result_display.sv | 190 +++++++++++++++++++
 tb/tb_alu_result_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result display: FSM states, segment
// patterns, digit positions, opcodes and the double-dabble adjust step.
package alu_disp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Digit positions on the display, an[0] is the rightmost digit
  localparam logic [1:0] ONES     = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;
  localparam logic [1:0] SIGN     = 2'd3;

  // ALU opcode whose result is interpreted as two's complement
  localparam logic [1:0] OP_SUB = 2'b01;

  // Number of shift steps for an 8-bit magnitude
  localparam logic [2:0] LAST_SHIFT = 3'd7;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [11:0] dd_adjust(input logic [11:0] work);
    logic [11:0] adj;
    adj = work;
    for (int i = 0; i < 3; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = work[4*i +: 4];
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/alu_result_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes are shown as a blank digit.
module bcd_to_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import alu_disp_pkg::*;

  // Pattern lookup for decimal digits, everything else blanks the digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result, converts it to three BCD digits with a
// one-shift-per-cycle double-dabble engine (sign extracted for subtraction),
// and scans the value onto a 4-digit active-low seven-segment display.
module alu_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  result,
  input  logic [1:0]  ctrl,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  import alu_disp_pkg::*;

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_ZERO = SCAN_W'(0);

  state_t      state_r;
  logic [7:0]  mag_r;
  logic [11:0] work_r;
  logic [2:0]  shift_cnt_r;
  logic        neg_pend_r;

  logic [7:0]  cap_mag_s;
  logic        cap_neg_s;
  logic [11:0] work_adj_s;
  logic [19:0] shifted_s;

  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        dig_idx_r;
  logic [3:0]        dig_val_s;
  logic [6:0]        dig_seg_s;
  logic [6:0]        seg_next_s;
  logic [3:0]        an_next_s;

  // Magnitude and sign of the incoming result; only subtraction is signed
  always_comb begin
    cap_mag_s = result;
    cap_neg_s = 1'b0;
    if ((ctrl == OP_SUB) && result[7]) begin
      cap_mag_s = ~result + 8'd1;
      cap_neg_s = 1'b1;
    end else begin
      cap_mag_s = result;
      cap_neg_s = 1'b0;
    end
  end

  // One double-dabble step: correct the BCD nibbles, then shift {bcd, mag}
  always_comb begin
    work_adj_s = dd_adjust(work_r);
    shifted_s  = {work_adj_s, mag_r} << 1;
  end

  // Conversion FSM; bcd/neg only change when a full conversion lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mag_r       <= 8'h00;
      work_r      <= 12'h000;
      shift_cnt_r <= 3'd0;
      neg_pend_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= 12'h000;
      neg         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            mag_r       <= cap_mag_s;
            neg_pend_r  <= cap_neg_s;
            work_r      <= 12'h000;
            shift_cnt_r <= 3'd0;
            busy        <= 1'b1;
            state_r     <= ST_CONVERT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          work_r      <= shifted_s[19:8];
          mag_r       <= shifted_s[7:0];
          shift_cnt_r <= shift_cnt_r + 3'd1;
          if (shift_cnt_r == LAST_SHIFT) begin
            bcd     <= shifted_s[19:8];
            neg     <= neg_pend_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= ST_CONVERT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running refresh divider; each wrap advances to the next digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_r <= SCAN_ZERO;
      dig_idx_r  <= ONES;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= SCAN_ZERO;
      dig_idx_r  <= dig_idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_ONE;
      dig_idx_r  <= dig_idx_r;
    end
  end

  // Select the BCD nibble feeding the shared decoder
  always_comb begin
    dig_val_s = bcd[3:0];
    case (dig_idx_r)
      ONES:     dig_val_s = bcd[3:0];
      TENS:     dig_val_s = bcd[7:4];
      HUNDREDS: dig_val_s = bcd[11:8];
      default:  dig_val_s = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (dig_val_s),
    .seg   (dig_seg_s)
  );

  // Leading-zero blanking and the sign position
  always_comb begin
    seg_next_s = SEG_BLANK;
    an_next_s  = ~(4'b0001 << dig_idx_r);
    case (dig_idx_r)
      ONES: begin
        seg_next_s = dig_seg_s;
      end
      TENS: begin
        if ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) begin
          seg_next_s = SEG_BLANK;
        end else begin
          seg_next_s = dig_seg_s;
        end
      end
      HUNDREDS: begin
        if (bcd[11:8] == 4'd0) begin
          seg_next_s = SEG_BLANK;
        end else begin
          seg_next_s = dig_seg_s;
        end
      end
      SIGN: begin
        if (neg) begin
          seg_next_s = SEG_MINUS;
        end else begin
          seg_next_s = SEG_BLANK;
        end
      end
      default: begin
        seg_next_s = SEG_BLANK;
      end
    endcase
  end

  // Register segment and anode drives together so they switch in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_ZERO;
      an  <= 4'b1110;
    end else begin
      seg <= seg_next_s;
      an  <= an_next_s;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized self-checking bench for alu_result_display against an
// arithmetic reference model of the conversion and of the display scan.
module tb_alu_result_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  result;
  logic [1:0]  ctrl;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        neg;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: value and sign of the last completed conversion
  int exp_val = 0;
  bit exp_neg = 1'b0;

  // Edges since reset was released (0 while in reset)
  int unsigned k = 0;

  logic [6:0] pat [10];

  alu_result_display #(.SCAN_DIV(SD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .result (result),
    .ctrl   (ctrl),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .neg    (neg),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[11:8] = 4'(v / 100);
    b[7:4]  = 4'((v / 10) % 10);
    b[3:0]  = 4'(v % 10);
    return b;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    int h, t, o;
    h = exp_val / 100;
    t = (exp_val / 10) % 10;
    o = exp_val % 10;
    case (idx)
      0:       return pat[o];
      1:       return (h == 0 && t == 0) ? 7'b1111111 : pat[t];
      2:       return (h == 0) ? 7'b1111111 : pat[h];
      default: return exp_neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Compare the scanned display for n cycles against the model
  task automatic disp_check(input int n);
    int idx;
    logic [3:0] ea;
    repeat (n) begin
      @(negedge clk);
      idx = (k == 0) ? 0 : int'(((k - 1) / SD) % 4);
      ea = 4'b1111;
      ea[idx] = 1'b0;
      check("an", {28'd0, an}, {28'd0, ea});
      check("seg", {25'd0, seg}, {25'd0, exp_seg(idx)});
    end
  endtask

  // One conversion; optionally re-pulse load or drop reset at a given cycle
  task automatic convert(input logic [1:0] c, input logic [7:0] r,
                         input int reload_at, input int abort_at);
    int mag;
    bit ng;
    logic [14:0] st;
    if (c == 2'b01 && r >= 8'd128) begin
      mag = 256 - int'(r);
      ng  = 1'b1;
    end else begin
      mag = int'(r);
      ng  = 1'b0;
    end
    @(negedge clk);
    ctrl = c; result = r; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("busy_e0", {30'd0, busy, done}, 32'd2);
    for (int i = 1; i <= 8; i++) begin
      if (i == reload_at) begin
        load = 1'b1; result = 8'd5; ctrl = 2'b00;
      end
      if (i == abort_at) rst_n = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      st = {busy, done, neg, bcd};
      if (i == abort_at) begin
        exp_val = 0; exp_neg = 1'b0;
        check("abort", {17'd0, st}, 32'd0);
        repeat (10) begin
          @(posedge clk); #1;
          check("abort_nodone", {30'd0, busy, done}, 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (i < 8) begin
        check("hold", {17'd0, st}, {17'd0, 2'b10, exp_neg, to_bcd(exp_val)});
      end else begin
        exp_val = mag; exp_neg = ng;
        check("done", {17'd0, st}, {17'd0, 2'b01, exp_neg, to_bcd(exp_val)});
      end
    end
    @(posedge clk); #1;
    st = {busy, done, neg, bcd};
    check("after", {17'd0, st}, {17'd0, 2'b00, exp_neg, to_bcd(exp_val)});
  endtask

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;

    rst_n = 1'b0; load = 1'b0; ctrl = 2'b00; result = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {17'd0, busy, done, neg, bcd}, 32'd0);
    check("rst_an", {28'd0, an}, 32'hE);
    check("rst_seg", {25'd0, seg}, 32'h40);
    rst_n = 1'b1;
    disp_check(20);

    convert(2'b00, 8'd18, 0, 0);
    disp_check(8);
    convert(2'b01, 8'hFC, 0, 0);
    disp_check(16);
    convert(2'b00, 8'hFC, 0, 0);
    disp_check(16);
    convert(2'b00, 8'd99, 3, 0);
    disp_check(8);
    convert(2'b00, 8'd123, 0, 4);
    disp_check(16);
    convert(2'b00, 8'd7, 0, 0);
    disp_check(20);

    // Boundary values
    convert(2'b01, 8'h80, 0, 0);
    disp_check(16);
    convert(2'b01, 8'h00, 0, 0);
    convert(2'b00, 8'hFF, 0, 0);
    convert(2'b01, 8'h7F, 0, 0);
    convert(2'b10, 8'hFF, 0, 0);
    convert(2'b11, 8'h81, 0, 0);
    disp_check(16);

    for (int n = 0; n < 40; n++) begin
      convert(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 0, 0);
      if (n % 4 == 0) disp_check(16);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
